fifo_uart_tx: RTL and testbench

//  Downstream drain stage for synchronous_fifo. Pops one word whenever the FIFO is non-empty
//  and serialises it on a UART line: start bit, data bits LSB first, optional parity, one stop bit.

---
 rtl/fifo_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and serialises it as a UART frame.
// Optional even-parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic [BIT_W-1:0]      r_bit, w_bit_nx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nx;
  logic                  r_tx, r_busy, r_done;
  logic                  w_tx_nx, w_busy_nx, w_done_nx;
  logic                  w_ren, w_cnt_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_par, w_par_nx;
`endif

  assign w_ren     = !rst && (r_state == S_IDLE) && !fifo_empty;
  assign w_cnt_end = (r_cnt == CNT_LAST);

  assign fifo_r_en = w_ren;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign tx_done   = r_done;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
`ifdef FIFO_UART_TX_PARITY_EN
    w_par_nx   = r_par;
`endif
    unique case (r_state)
      S_IDLE: if (w_ren) w_state_nx = S_FETCH;
      S_FETCH: begin
        w_shift_nx = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        w_par_nx   = ^fifo_data;
`endif
        w_cnt_nx   = '0;
        w_bit_nx   = '0;
        w_state_nx = S_START;
      end
      S_START: begin
        if (w_cnt_end) begin
          w_cnt_nx   = '0;
          w_state_nx = S_DATA;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_cnt_end) begin
          w_cnt_nx   = '0;
          w_shift_nx = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_nx = S_PARITY;
`else
            w_state_nx = S_STOP;
`endif
          end else begin
            w_bit_nx = r_bit + BIT_W'(1);
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_end) begin
          w_cnt_nx   = '0;
          w_state_nx = S_STOP;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_cnt_end) begin
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase

    // Outputs are decoded from next-state values so the registered copies line up with r_state.
    w_tx_nx = 1'b1;
    case (w_state_nx)
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_shift_nx[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: w_tx_nx = w_par_nx;
`endif
      default:  w_tx_nx = 1'b1;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
    w_done_nx = (w_state_nx == S_STOP) && (w_cnt_nx == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
`ifdef FIFO_UART_TX_PARITY_EN
      r_par   <= w_par_nx;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4) with a 1-cycle-latency FIFO model.
module tb_fifo_uart_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME = 1 + (W + 3) * C;
`else
  localparam int FRAME = 1 + (W + 2) * C;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_r_en, tx, busy, tx_done;

  fifo_uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered empty flag, data valid the cycle after the read strobe
  logic [W-1:0] fq[$];
  logic         toggle_en = 1'b0;

  always @(posedge clk) begin
    if (fifo_r_en) begin
      chk("read_not_empty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) fifo_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0) || (toggle_en && ($urandom_range(0, 1) == 1));
  end

  // Event monitor sampled on the falling edge
  int cyc = 0, ren_cnt = 0, done_cnt = 0, last_ren = 0, last_done = 0;
  int since_done = 0, last_gap = -1;
  logic armed = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (fifo_r_en) begin ren_cnt++; last_ren = cyc; end
    if (tx_done) begin
      done_cnt++; last_done = cyc; since_done = 0; armed = 1'b1;
    end else if (armed) begin
      if (tx === 1'b0) begin last_gap = since_done; armed = 1'b0; end
      else since_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_start();
    int t = 0;
    while (tx !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    chk("start_seen", 32'(tx), 32'd0);
  endtask

  task automatic rx_frame(output logic [W-1:0] d);
    d = '0;
    wait_start();
    if (tx !== 1'b0) return;
    repeat (2) @(negedge clk);
    chk("start_bit", 32'(tx), 32'd0);
    for (int b = 0; b < W; b++) begin
      repeat (C) @(negedge clk);
      d[b] = tx;
    end
`ifdef FIFO_UART_TX_PARITY_EN
    repeat (C) @(negedge clk);
    chk("parity_bit", 32'(tx), 32'(^d));
`endif
    repeat (C) @(negedge clk);
    chk("stop_bit", 32'(tx), 32'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  logic [W-1:0] d;
  logic [W-1:0] exp_q[$];
  int base_ren, base_done, t;

  initial begin
    // 1: reset held, FIFO empty
    repeat (5) begin
      @(negedge clk);
      chk("reset_hold", 32'({tx, busy, fifo_r_en, tx_done}), 32'b1000);
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_after_reset", 32'({tx, busy, fifo_r_en, tx_done}), 32'b1000);
    end

    // 2: single word 0xA5
    base_ren = ren_cnt; base_done = done_cnt;
    fq.push_back(8'hA5);
    rx_frame(d);
    chk("frame_A5", 32'(d), 32'hA5);
    settle(4);
    chk("ren_pulses_A5", 32'(ren_cnt - base_ren), 32'd1);
    chk("done_pulses_A5", 32'(done_cnt - base_done), 32'd1);
    chk("done_latency", 32'(last_done - last_ren), 32'(FRAME));
    chk("idle_after_A5", 32'({tx, busy}), 32'b10);

    // 3: back-to-back words
    base_ren = ren_cnt;
    fq.push_back(8'h00); fq.push_back(8'hFF); fq.push_back(8'h3C);
    rx_frame(d); chk("b2b_0", 32'(d), 32'h00);
    rx_frame(d); chk("b2b_1", 32'(d), 32'hFF);
    chk("gap_0_1", 32'(last_gap), 32'd2);
    rx_frame(d); chk("b2b_2", 32'(d), 32'h3C);
    chk("gap_1_2", 32'(last_gap), 32'd2);
    settle(6);
    chk("b2b_ren_pulses", 32'(ren_cnt - base_ren), 32'd3);
    chk("b2b_drained", 32'(fq.size()), 32'd0);

    // 4: reset mid-DATA of 0x81 with 0x42 queued
    fq.push_back(8'h81); fq.push_back(8'h42);
    wait_start();
    repeat (10) @(negedge clk);
    chk("in_frame_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    base_ren = ren_cnt;
    @(posedge clk); #1 rst = 1'b0;
    rx_frame(d);
    chk("after_rst_frame", 32'(d), 32'h42);
    settle(8);
    chk("after_rst_ren", 32'(ren_cnt - base_ren), 32'd1);
    chk("after_rst_idle", 32'(busy), 32'd0);

    // 5: fill and drain with scoreboard
    for (int i = 0; i < 8; i++) begin
      d = W'($urandom_range(0, 255));
      fq.push_back(d); exp_q.push_back(d);
    end
    for (int i = 0; i < 8; i++) begin
      rx_frame(d);
      chk("scoreboard", 32'(d), 32'(exp_q.pop_front()));
    end
    settle(6);
    chk("drain_empty", 32'(fq.size()), 32'd0);

    // 6: empty flag toggling during a frame
    fq.push_back(8'h01); fq.push_back(8'h02);
    toggle_en = 1'b1;
    rx_frame(d);
    toggle_en = 1'b0;
    chk("toggle_frame", 32'(d), 32'h01);
    base_done = done_cnt; base_ren = ren_cnt;
    t = 0;
    while (ren_cnt == base_ren && t < 200) begin settle(1); t++; end
    chk("toggle_next_ren", 32'(ren_cnt - base_ren), 32'd1);
    chk("toggle_done_before_ren", 32'(done_cnt - base_done), 32'd1);
    chk("ren_after_done", 32'(last_ren > last_done), 32'd1);
    rx_frame(d);
    chk("toggle_second", 32'(d), 32'h02);
    settle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
